io_mem_scheduler: RTL
=====================

Name: io_mem_scheduler

Overview:
Request/acknowledge scheduler that shares the single URISC memory port among IO devices (VGA, keyboard, ...). It replaces free-running time slicing with demand-driven round-robin grants. Each device raises a request with address, data and direction. The scheduler serialises these into one memory transaction at a time, waiting on a memory ready handshake, then returns an acknowledge and read data to the granted device.

Parameters:
IO_COUNT, gc::IO_COUNT, number of requesting IO devices (>=2)
WORD_SIZE, 8, memory data width in bits
ADDR_WIDTH, 8, memory address width in bits
CNT_WIDTH, 16, width of per-device grant counters (used only with the optional feature)

Ports:
clk  input  1  single clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
req  input  [IO_COUNT-1:0]  per-device request; held high until ack
dirArr  input  1 x [IO_COUNT]  per-device direction; gc::IO_IN = write to memory, gc::IO_OUT = read from memory
addressInArr  input  [ADDR_WIDTH-1:0] x [IO_COUNT]  per-device address
dataInArr  input  [WORD_SIZE-1:0] x [IO_COUNT]  per-device write data
ack  output  [IO_COUNT-1:0]  one-hot, one-cycle completion pulse
dataOut  output  WORD_SIZE  read data; valid in the ack cycle of a read
grantId  output  $clog2(IO_COUNT)  index of the device currently being served
busy  output  1  high from grant until the ack cycle inclusive
memEn  output  1  memory transaction strobe
memWe  output  1  1 = write
memAdd  output  ADDR_WIDTH  memory address
memWData  output  WORD_SIZE  memory write data
memRData  input  WORD_SIZE  memory read data, valid with memReady
memReady  input  1  memory completes the current transaction

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE, ptr=0, ack=0, dataOut=0, grantId=0, busy=0, memEn=0, memWe=0, memAdd=0, memWData=0. Reset applies from any state; an in-flight transaction is abandoned with no ack.
- FSM states are IDLE, ISSUE and ACK.
- IDLE:
  - If req is zero, stay in IDLE.
  - Otherwise pick the first set req[i] in search order ptr, ptr+1, ..., wrapping modulo IO_COUNT.
  - Latch i, address, data and direction into registers, set grantId=i and busy=1, then go to ISSUE.
- ISSUE:
  - memEn=1, memWe=(latched dir==gc::IO_IN), memAdd and memWData driven from the latched registers.
  - These outputs stay stable while memReady=0; there is no timeout.
  - On memReady=1: for a read, register memRData into dataOut; then go to ACK.
- ACK:
  - ack[grantId]=1 for exactly one cycle; memEn=0, busy=1.
  - ptr <= (grantId==IO_COUNT-1) ? 0 : grantId+1.
  - Next state is IDLE.
- dataOut holds its value until the next read completes. Writes leave dataOut unchanged.
- Latency: req seen in cycle N gives memEn in N+1. memReady first sampled high in cycle M gives ack in M+1. Minimum 3 cycles request-to-ack; back-to-back throughput is one transaction per 3 cycles.
- Requester rules:
  - req, address, data and direction must stay stable until ack.
  - The device drops req in the cycle after ack; req still high in IDLE counts as a new request.
- Withdrawing req after grant has no effect; the transaction completes and ack still pulses.
- memReady outside ISSUE is ignored.
- Requests arriving during ISSUE or ACK wait for IDLE.
- ack is never asserted for more than one device at a time.

Optional Feature:
IOSCHED_GRANT_CNT_EN
- Defined: adds output grantCnt [CNT_WIDTH-1:0] x [IO_COUNT].
  - grantCnt[i] increments in each ack[i] cycle and saturates at all-ones.
  - Reset value is 0.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package gc:
  - IO_COUNT and IO_IN/IO_OUT already live here.
  - Add the typedef enum io_sched_state_t {IDLE, ISSUE, ACK}.
  - Add the IO_SCHED_MIN_LATENCY=3 constant.
- Sub-module rr_picker: combinational function of (req, ptr) returning found and index. It is reused by later arbiters.

Test Plan:
1. Read, IO_COUNT=3: req[1]=1, addr 0x12, IO_OUT in cycle 0; memReady=1 in cycle 2 with memRData 0xA5 -> memEn=1 in cycles 1-2, memAdd=0x12, ack=3'b010 and dataOut=0xA5 in cycle 3.
2. Write held: req[2], IO_IN, addr 0x40, data 0x3C; memReady low for 5 cycles -> memEn, memWe=1, memAdd=0x40, memWData=0x3C stable all 5 cycles; single ack[2] after memReady.
3. Fairness: req=3'b111 held continuously, memReady tied high -> ack sequence 0,1,2,0,1,2, one per 3 cycles.
4. Wrap: last grant 2, then req=3'b101 -> device 0 granted first, then device 2.
5. Reset mid-ISSUE: rst=1 for one cycle while memEn=1 -> memEn=0 next cycle, no ack, ptr=0; req=3'b110 afterwards grants 1 first.
6. With IOSCHED_GRANT_CNT_EN and CNT_WIDTH=8: 300 grants to device 0 -> grantCnt[0]=255, others 0.

Source files
------------

// File: rtl/io_mem_scheduler_pkg.sv
// Shared constants for the IO memory scheduler: device count, direction codes and FSM state type.
`timescale 1ns/1ps
package gc;
    localparam int   IO_COUNT             = 3;
    localparam logic IO_IN                = 1'b1;  // device writes to memory
    localparam logic IO_OUT               = 1'b0;  // device reads from memory
    localparam int   IO_SCHED_MIN_LATENCY = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, ACK} io_sched_state_t;
endpackage

// File: rtl/io_mem_scheduler_rr_picker.sv
// Round-robin picker: returns the first set request at or after ptr_i, wrapping modulo N.
`timescale 1ns/1ps
module rr_picker #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);
    int cand;

    // Scan from the farthest offset down so the offset closest to ptr_i wins.
    always_comb begin
        found_o = |req_i;
        idx_o   = '0;
        cand    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = (int'(ptr_i) + k) % N;
            if (req_i[cand]) begin
                idx_o = W'(cand);
            end
        end
    end
endmodule

// File: rtl/io_mem_scheduler.sv
// Demand-driven round-robin scheduler sharing one memory port among IO devices.
// Optional per-device saturating grant counters are enabled with `define IOSCHED_GRANT_CNT_EN.
`timescale 1ns/1ps
module io_mem_scheduler #(
    parameter int IO_COUNT   = gc::IO_COUNT,
    parameter int WORD_SIZE  = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [IO_COUNT-1:0]                  req,
    input  logic [IO_COUNT-1:0]                  dirArr,
    input  logic [IO_COUNT-1:0][ADDR_WIDTH-1:0]  addressInArr,
    input  logic [IO_COUNT-1:0][WORD_SIZE-1:0]   dataInArr,
    output logic [IO_COUNT-1:0]                  ack,
    output logic [WORD_SIZE-1:0]                 dataOut,
    output logic [$clog2(IO_COUNT)-1:0]          grantId,
    output logic                                 busy,
    output logic                                 memEn,
    output logic                                 memWe,
    output logic [ADDR_WIDTH-1:0]                memAdd,
    output logic [WORD_SIZE-1:0]                 memWData,
`ifdef IOSCHED_GRANT_CNT_EN
    output logic [IO_COUNT-1:0][CNT_WIDTH-1:0]   grantCnt,
`endif
    input  logic [WORD_SIZE-1:0]                 memRData,
    input  logic                                 memReady
);
    import gc::*;

    localparam int ID_W = $clog2(IO_COUNT);

    io_sched_state_t        state_q, state_d;
    logic [ID_W-1:0]        ptr_q;
    logic [ID_W-1:0]        grant_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [WORD_SIZE-1:0]   wdata_q;
    logic                   dir_q;
    logic [WORD_SIZE-1:0]   dout_q;
    logic                   pick_found;
    logic [ID_W-1:0]        pick_idx;

    rr_picker #(
        .N (IO_COUNT),
        .W (ID_W)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = ISSUE;
            ISSUE:   if (memReady)   state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        memEn = (state_q == ISSUE);
        memWe = (state_q == ISSUE) && (dir_q == IO_IN);
        busy  = (state_q != IDLE);
        ack   = '0;
        if (state_q == ACK) begin
            ack[grant_q] = 1'b1;
        end
    end

    // Request fields are captured at grant so a device withdrawing req cannot disturb the transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            dir_q   <= IO_OUT;
            dout_q  <= '0;
        end else begin
            if (state_q == IDLE && pick_found) begin
                grant_q <= pick_idx;
                addr_q  <= addressInArr[pick_idx];
                wdata_q <= dataInArr[pick_idx];
                dir_q   <= dirArr[pick_idx];
            end
            if (state_q == ISSUE && memReady && dir_q == IO_OUT) begin
                dout_q <= memRData;
            end
            if (state_q == ACK) begin
                ptr_q <= (grant_q == ID_W'(IO_COUNT - 1)) ? '0 : grant_q + ID_W'(1);
            end
        end
    end

    assign dataOut  = dout_q;
    assign grantId  = grant_q;
    assign memAdd   = addr_q;
    assign memWData = wdata_q;

`ifdef IOSCHED_GRANT_CNT_EN
    generate
        for (genvar gi = 0; gi < IO_COUNT; gi++) begin : g_grant_cnt
            logic [CNT_WIDTH-1:0] cnt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (ack[gi] && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                end
            end

            assign grantCnt[gi] = cnt_q;
        end
    endgenerate
`else
    // Grant statistics are not built in this configuration.
`endif
endmodule
